// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between a value producer and the seven-segment scan controller.
// The producer uses the master modport; the controller uses the slave modport.
interface seven_seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load_valid;
    logic [4*DIGITS-1:0]   load_value;
    logic                  load_ready;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered BCD load port.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_ctrl_if.slave load_if,
    output logic [6:0]           seg_out,
    output logic [DIGITS-1:0]    digit_sel,
    output logic                 frame_done
);
    localparam int DIV_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int VAL_W  = 4 * DIGITS;
    localparam int NIB_N  = 2 ** IDX_W;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [VAL_W-1:0]  active_q, active_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dsel_q, dsel_d;
    logic              fd_q, fd_d;

    logic slot_end;
    logic frame_end;
    logic ready;
    logic accept;
    logic [3:0] nib [NIB_N];

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign slot_end  = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
    // Ready is forced low during reset so nothing can be accepted into a register being cleared.
    assign ready     = ~pend_full_q & ~rst;
    assign accept    = load_if.load_valid & ready;
    assign load_if.load_ready = ready;

    always_comb begin
        div_d       = div_q + DIV_W'(1);
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        fd_d        = 1'b0;
        if (slot_end) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_end) begin
            fd_d = 1'b1;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end
        end
        // Cannot collide with the transfer above: ready is low whenever pending is full.
        if (accept) begin
            pend_d      = load_if.load_value;
            pend_full_d = 1'b1;
        end
    end

    // Decode from next-state values so outputs change on the same edge as the scan position.
    for (genvar gi = 0; gi < NIB_N; gi++) begin : g_nib
        if (gi < DIGITS) begin : g_real
            assign nib[gi] = active_d[4*gi +: 4];
        end else begin : g_pad
            assign nib[gi] = 4'hF;
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    logic [DIGITS-1:0] nz;
    logic [DIGITS-1:0] nz_above;
    logic [NIB_N-1:0]  lz_blank;

    assign nz_above[DIGITS-1] = 1'b0;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
        assign nz[gi] = |active_d[4*gi +: 4];
        if (gi < DIGITS - 1) begin : g_above
            assign nz_above[gi] = nz_above[gi+1] | nz[gi+1];
        end
        if (gi == 0) begin : g_keep0
            assign lz_blank[gi] = 1'b0;
        end else begin : g_blank
            assign lz_blank[gi] = ~nz[gi] & ~nz_above[gi];
        end
    end
    for (genvar gi = DIGITS; gi < NIB_N; gi++) begin : g_lzb_pad
        assign lz_blank[gi] = 1'b0;
    end
`endif

    always_comb begin
        seg_d = bcd_to_seg(nib[idx_d]);
`ifdef SEVEN_SEG_LZB_EN
        if (lz_blank[idx_d]) begin
            seg_d = 7'b1111111;
        end
`endif
        dsel_d = (div_d < DIV_W'(BLANK_CYC)) ? '1 : ~(DIGITS'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            active_q    <= '0;
            seg_q       <= 7'b1111111;
            dsel_q      <= '1;
            fd_q        <= 1'b0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            active_q    <= active_d;
            seg_q       <= seg_d;
            dsel_q      <= dsel_d;
            fd_q        <= fd_d;
        end
    end

    assign seg_out    = seg_q;
    assign digit_sel  = dsel_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized scoreboard bench for seven_seg_scan_ctrl (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2).
// Expected display values come from a frame-level model of the load/display rules.
module tb_seven_seg_scan_ctrl;
    localparam int D     = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = D * RD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_seen = 1'b1;
    logic [6:0] seg_out;
    logic [3:0] digit_sel;
    logic       frame_done;
    int         cyc = 0;
    int         ready_at = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    logic [15:0] exp_active = '0;

    typedef struct {
        int          frame;
        logic [15:0] val;
    } exp_t;
    exp_t sb_q[$];

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h0C, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    seven_seg_scan_ctrl_if #(.DIGITS(D)) lif ();

    seven_seg_scan_ctrl #(
        .DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYC(BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (lif),
        .seg_out    (seg_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_seen <= rst;
        cyc      <= rst ? 0 : cyc + 1;
    end

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
        logic [15:0] upper;
        upper = v >> (4 * i);
`ifdef SEVEN_SEG_LZB_EN
        if (i > 0 && upper == 16'h0) return 7'h7F;
`endif
        return seg_tab[upper[3:0]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: display timing from scan arithmetic, segment values from the scoreboard.
    always @(negedge clk) begin
        int p;
        int f;
        int slot;
        int dv;
        if (rst) chk("load_ready_rst", {31'd0, lif.load_ready}, 32'd0);
        else     chk("load_ready", {31'd0, lif.load_ready}, {31'd0, cyc >= ready_at});
        if (rst_seen) begin
            chk("seg_rst", {25'd0, seg_out}, 32'h7F);
            chk("dsel_rst", {28'd0, digit_sel}, 32'hF);
            chk("fd_rst", {31'd0, frame_done}, 32'd0);
            exp_active = '0;
        end else begin
            p    = cyc % FRAME;
            f    = cyc / FRAME;
            slot = p / RD;
            dv   = p % RD;
            if (p == 0) begin
                if (sb_q.size() > 0 && sb_q[0].frame == f) begin
                    exp_active = sb_q[0].val;
                    sb_q.pop_front();
                end
                if (sb_q.size() > 0) chk("sb_order", {31'd0, sb_q[0].frame > f}, 32'd1);
            end
            chk("digit_sel", {28'd0, digit_sel},
                (dv < BC) ? 32'hF : {28'd0, ~(4'b0001 << slot)});
            chk("frame_done", {31'd0, frame_done}, {31'd0, p == 0});
            if (dv >= BC) chk("seg_out", {25'd0, seg_out}, {25'd0, exp_seg(exp_active, slot)});
        end
    end

    // One cycle of stimulus; the acceptance decision is committed after the edge.
    task automatic drive_cycle(input logic v, input logic [15:0] val);
        bit acc;
        int t_now;
        int vis;
        lif.load_valid = v;
        lif.load_value = val;
        acc   = v && !rst && (cyc >= ready_at);
        t_now = cyc;
        @(posedge clk);
        #1;
        if (acc) begin
            vis = (t_now + 1) / FRAME + 1;
            sb_q.push_back('{frame: vis, val: val});
            ready_at = FRAME * vis;
            $display("load %04h accepted at t=%0d, shown from frame %0d", val, t_now, vis);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0);
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait bound expired (t=%0d)", name, cyc);
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 3 * FRAME && cyc < ready_at; k++) drive_cycle(1'b0, 16'h0);
        if (cyc < ready_at) bound_fail("wait_ready");
    endtask

    task automatic wait_pos(input int target);
        int k;
        for (k = 0; k < 2 * FRAME && (cyc % FRAME) != target; k++) drive_cycle(1'b0, 16'h0);
        if ((cyc % FRAME) != target) bound_fail("wait_pos");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lif.load_valid = 1'b0;
        sb_q.delete();
        ready_at = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        int n;
        v = '0;
        for (int i = 0; i < D; i++) begin
            n = $urandom_range(0, 12);
            if (n > 9) n = $urandom_range(10, 15);
            v[4*i +: 4] = 4'(n);
        end
        if ($urandom_range(0, 3) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(1, 3)));
        return v;
    endfunction

    initial begin
        int k;
        lif.load_valid = 1'b0;
        lif.load_value = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle scan after reset: all digits show 0.
        idle(2 * FRAME);

        // Single mid-frame load.
        wait_pos(10);
        drive_cycle(1'b1, 16'h4321);
        idle(2 * FRAME);

        // Overwrite attempt while pending is full.
        wait_ready();
        wait_pos(5);
        drive_cycle(1'b1, 16'h1111);
        for (int i = 0; i < 70; i++) drive_cycle(1'b1, 16'h9999);
        idle(2 * FRAME);

        // Load exactly on the frame-boundary cycle.
        wait_ready();
        wait_pos(FRAME - 1);
        drive_cycle(1'b1, 16'h0A05);
        idle(3 * FRAME);

        // Leading-zero cases.
        wait_ready();
        drive_cycle(1'b1, 16'h0050);
        idle(2 * FRAME);
        wait_ready();
        drive_cycle(1'b1, 16'h0000);
        idle(2 * FRAME);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) drive_cycle(1'b1, rand_val());
            else                           drive_cycle(1'b0, 16'h0);
        end

        // Reset mid-slot with pending full.
        wait_ready();
        drive_cycle(1'b1, 16'h8765);
        wait_ready();
        idle(2 * FRAME);
        drive_cycle(1'b1, rand_val());
        for (k = 0; k < FRAME && !((cyc % RD) == 5 && cyc < ready_at); k++) drive_cycle(1'b0, 16'h0);
        if (!((cyc % RD) == 5 && cyc < ready_at)) bound_fail("wait_div5");
        do_reset();
        idle(2 * FRAME);

        // A little more random traffic, then drain.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) drive_cycle(1'b1, rand_val());
            else                           drive_cycle(1'b0, 16'h0);
        end
        idle(3 * FRAME);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
